sda_gmem_read_arbiter: RTL and testbench
========================================

// Module: sda_gmem_read_arbiter
// PURPOSE
//  Shares the single gmem AXI master read path (AR and R channels) between
//  NUM_PORTS requesters inside the kernel action core.
//  - Round-robin arbitration on AR.
//  - An in-order route FIFO steers each returning R burst back to its issuer.
//  - Sits between the action datapath read engines and the m_axi_gmem_AR*/R* pins.
//  - Single AXI ID, so bursts complete in issue order.
// PARAMETERS
//  NUM_PORTS      2   requester count, 2..4
//  ADDR_WIDTH     64  AXI address width
//  DATA_WIDTH     32  AXI read data width
//  ROUTE_DEPTH    4   max outstanding bursts (route FIFO entries), power of 2
//  ROUTE_PTR_BITS 2   log2(ROUTE_DEPTH)
// PORTS
//  clk          in   1                     kernel clock
//  reset        in   1                     synchronous, active-high
//  s_araddr     in   NUM_PORTS*ADDR_WIDTH  per-port read address, port i at [i*AW +: AW]
//  s_arlen      in   NUM_PORTS*8           per-port burst length - 1
//  s_arsize     in   NUM_PORTS*3           per-port beat size
//  s_arvalid    in   NUM_PORTS             per-port AR valid
//  s_arready    out  NUM_PORTS             per-port AR accept
//  s_rdata      out  DATA_WIDTH            R data, broadcast to all ports
//  s_rresp      out  2                     R response, broadcast
//  s_rlast      out  1                     R last, broadcast
//  s_rvalid     out  NUM_PORTS             per-port R valid
//  s_rready     in   NUM_PORTS             per-port R ready
//  m_araddr     out  ADDR_WIDTH            to m_axi_gmem_ARADDR
//  m_arlen      out  8                     to m_axi_gmem_ARLEN
//  m_arsize     out  3                     to m_axi_gmem_ARSIZE
//  m_arvalid    out  1                     to m_axi_gmem_ARVALID
//  m_arready    in   1                     from m_axi_gmem_ARREADY
//  m_rdata      in   DATA_WIDTH            from m_axi_gmem_RDATA
//  m_rresp      in   2                     from m_axi_gmem_RRESP
//  m_rlast      in   1                     from m_axi_gmem_RLAST
//  m_rvalid     in   1                     from m_axi_gmem_RVALID
//  m_rready     out  1                     to m_axi_gmem_RREADY
// BEHAVIOUR
//  Reset: all of the following are 0.
//   - Outputs: m_arvalid, m_araddr, m_arlen, m_arsize, s_arready, s_rvalid, m_rready.
//   - State: RR pointer, FIFO count and pointers; FSM goes to IDLE.
//   - Reset mid-burst discards all outstanding routes; the upstream is reset in the same domain.
//  AR FSM, IDLE:
//   - Grant = first port with s_arvalid set, searching from the RR pointer upward with wrap.
//   - s_arready[g]=1 (combinational, one-hot) only when state==IDLE && count<ROUTE_DEPTH.
//   - On s_arvalid[g]&&s_arready[g]: latch addr/len/size into m_ar* regs, push g into the
//     route FIFO, RR pointer <= (g+1) mod NUM_PORTS, go to ISSUE.
//  AR FSM, ISSUE:
//   - m_arvalid=1 and m_ar* held stable until m_arready.
//   - On m_arready: m_arvalid<=0 next cycle, go to IDLE.
//  AR latency and throughput:
//   - s_ar handshake at cycle N gives m_arvalid at N+1.
//   - Peak rate is 1 AR per 2 cycles.
//  Route FIFO full (count==ROUTE_DEPTH): all s_arready=0; pending requests wait, none dropped.
//  R routing, head = FIFO head port index:
//   - s_rvalid[head] = m_rvalid && !empty; all other s_rvalid are 0.
//   - m_rready = !empty && s_rready[head]. R is combinational, zero latency.
//   - Pop on m_rvalid && m_rready && m_rlast.
//  R with empty FIFO (protocol error): m_rready=0, beat stalls, no s_rvalid asserted.
//  Simultaneous push and pop: count unchanged, both pointers advance.
//  Pointers wrap modulo ROUTE_DEPTH.
//  Width rule: FIFO entry is a port index of clog2(NUM_PORTS) bits, minimum 1.
// TESTING
//  1. Port0 AR addr 0x1000 len 3, m_arready=1:
//     -> s_arready[0] at cycle 0, m_arvalid at cycle 1 with addr 0x1000;
//        4 R beats reach only s_rvalid[0]; FIFO empty after rlast.
//  2. Ports 0 and 1 request together, RR pointer 0:
//     -> port0 issued first, then port1;
//        R bursts return in order to port0 then port1.
//  3. Issue 4 bursts with no R returns:
//     -> 5th s_arvalid sees s_arready=0 until the first rlast pop, then is accepted.
//  4. m_arready held 0 for 10 cycles:
//     -> m_arvalid and m_araddr stable throughout; no new s_arready.
//  5. s_rready[head]=0 mid-burst:
//     -> m_rready=0, beat held; resumes with no beat lost or duplicated.
//  6. reset asserted mid-burst with 2 routes outstanding:
//     -> next cycle all outputs 0, count 0, FSM IDLE.

Source files
------------

// File: rtl/sda_gmem_read_arbiter.sv
// Round-robin sharing of the single gmem AXI read master (AR + R) between NUM_PORTS
// read engines; an in-order route FIFO steers each returning R burst to its issuer.
module sda_gmem_read_arbiter #(
   parameter int NUM_PORTS      = 2,
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 32,
   parameter int ROUTE_DEPTH    = 4,
   parameter int ROUTE_PTR_BITS = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_araddr,
   input  logic [NUM_PORTS*8-1:0]          s_arlen,
   input  logic [NUM_PORTS*3-1:0]          s_arsize,
   input  logic [NUM_PORTS-1:0]            s_arvalid,
   output logic [NUM_PORTS-1:0]            s_arready,
   output logic [DATA_WIDTH-1:0]           s_rdata,
   output logic [1:0]                      s_rresp,
   output logic                            s_rlast,
   output logic [NUM_PORTS-1:0]            s_rvalid,
   input  logic [NUM_PORTS-1:0]            s_rready,
   output logic [ADDR_WIDTH-1:0]           m_araddr,
   output logic [7:0]                      m_arlen,
   output logic [2:0]                      m_arsize,
   output logic                            m_arvalid,
   input  logic                            m_arready,
   input  logic [DATA_WIDTH-1:0]           m_rdata,
   input  logic [1:0]                      m_rresp,
   input  logic                            m_rlast,
   input  logic                            m_rvalid,
   output logic                            m_rready
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CNT_W = ROUTE_PTR_BITS + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(ROUTE_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [ROUTE_PTR_BITS-1:0] PTR_ONE = ROUTE_PTR_BITS'(1);

   typedef enum logic {IDLE, ISSUE} ar_state_t;

   ar_state_t                 state;
   logic [IDX_W-1:0]          rr_ptr;
   logic [IDX_W-1:0]          grant;
   logic                      grant_valid;
   logic [IDX_W-1:0]          route_mem [ROUTE_DEPTH];
   logic [ROUTE_PTR_BITS-1:0] wr_ptr;
   logic [ROUTE_PTR_BITS-1:0] rd_ptr;
   logic [CNT_W-1:0]          count;
   logic [IDX_W-1:0]          head;
   logic                      fifo_empty;
   logic                      can_accept;
   logic                      ar_fire;
   logic                      r_pop;

   // Search from the round-robin pointer upward, wrapping, for the first requesting port.
   always_comb begin
      grant = '0;
      grant_valid = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!grant_valid && s_arvalid[(int'(rr_ptr) + k) % NUM_PORTS]) begin
            grant = IDX_W'((int'(rr_ptr) + k) % NUM_PORTS);
            grant_valid = 1'b1;
         end
      end
   end

   assign fifo_empty = (count == '0);
   assign can_accept = !reset && (state == IDLE) && (count < DEPTH_CNT);
   assign head       = route_mem[rd_ptr];

   always_comb begin
      s_arready = '0;
      if (can_accept && grant_valid)
         s_arready[grant] = 1'b1;
   end

   assign ar_fire = |(s_arvalid & s_arready);

   // R is routed with zero latency to whichever port issued the oldest outstanding burst.
   always_comb begin
      s_rvalid = '0;
      m_rready = 1'b0;
      if (!reset && !fifo_empty) begin
         s_rvalid[head] = m_rvalid;
         m_rready       = s_rready[head];
      end
   end

   assign s_rdata = m_rdata;
   assign s_rresp = m_rresp;
   assign s_rlast = m_rlast;
   assign r_pop   = m_rvalid && m_rready && m_rlast;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         m_araddr  <= '0;
         m_arlen   <= '0;
         m_arsize  <= '0;
         m_arvalid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ar_fire) begin
                  m_araddr  <= s_araddr[grant*ADDR_WIDTH +: ADDR_WIDTH];
                  m_arlen   <= s_arlen[grant*8 +: 8];
                  m_arsize  <= s_arsize[grant*3 +: 3];
                  m_arvalid <= 1'b1;
                  rr_ptr    <= IDX_W'((int'(grant) + 1) % NUM_PORTS);
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (m_arready) begin
                  m_arvalid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A reset discards every outstanding route; the requesters are reset alongside us.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (ar_fire) begin
            route_mem[wr_ptr] <= grant;
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (r_pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (ar_fire && !r_pop)
            count <= count + CNT_ONE;
         else if (r_pop && !ar_fire)
            count <= count - CNT_ONE;
      end
   end

endmodule

// File: tb/tb_sda_gmem_read_arbiter.sv
// Directed bench for sda_gmem_read_arbiter: AR round-robin, route FIFO steering,
// FIFO-full stall, AR backpressure, R backpressure and mid-burst reset.
module tb_sda_gmem_read_arbiter;

   localparam int NP = 2;
   localparam int AW = 64;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic [NP*AW-1:0] s_araddr;
   logic [NP*8-1:0] s_arlen;
   logic [NP*3-1:0] s_arsize;
   logic [NP-1:0]   s_arvalid;
   logic [NP-1:0]   s_arready;
   logic [DW-1:0]   s_rdata;
   logic [1:0]      s_rresp;
   logic            s_rlast;
   logic [NP-1:0]   s_rvalid;
   logic [NP-1:0]   s_rready;
   logic [AW-1:0]   m_araddr;
   logic [7:0]      m_arlen;
   logic [2:0]      m_arsize;
   logic            m_arvalid;
   logic            m_arready;
   logic [DW-1:0]   m_rdata;
   logic [1:0]      m_rresp;
   logic            m_rlast;
   logic            m_rvalid;
   logic            m_rready;

   int checks = 0;
   int failures = 0;

   sda_gmem_read_arbiter #(
      .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .ROUTE_DEPTH(4), .ROUTE_PTR_BITS(2)
   ) dut (
      .clk(clk), .reset(reset),
      .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ar(input int port, input logic [AW-1:0] addr, input logic [7:0] len);
      s_araddr[port*AW +: AW] = addr;
      s_arlen[port*8 +: 8]    = len;
      s_arsize[port*3 +: 3]   = 3'd2;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      s_araddr  = '0;
      s_arlen   = '0;
      s_arsize  = '0;
      s_arvalid = '0;
      s_rready  = '1;
      m_arready = 1'b1;
      m_rdata   = '0;
      m_rresp   = '0;
      m_rlast   = 1'b0;
      m_rvalid  = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (m_arvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_arvalid got=%b exp=0", m_arvalid); end
      checks++;
      if (m_araddr !== '0) begin failures++; $display("[TB] FAIL reset_m_araddr got=%h exp=0", m_araddr); end
      checks++;
      if (s_arready !== 2'b00) begin failures++; $display("[TB] FAIL reset_s_arready got=%b exp=00", s_arready); end
      checks++;
      if (m_rready !== 1'b0 || s_rvalid !== 2'b00) begin
         failures++; $display("[TB] FAIL reset_r got m_rready=%b s_rvalid=%b exp 0/00", m_rready, s_rvalid);
      end
   endtask

   task automatic test_single_burst();
      set_ar(0, 64'h1000, 8'd3);
      s_arvalid = 2'b01;
      #1;
      checks++;
      if (s_arready !== 2'b01) begin failures++; $display("[TB] FAIL single_arready got=%b exp=01", s_arready); end
      step();
      s_arvalid = 2'b00;
      #1;
      checks++;
      if (m_arvalid !== 1'b1 || m_araddr !== 64'h1000 || m_arlen !== 8'd3) begin
         failures++; $display("[TB] FAIL single_m_ar got v=%b a=%h l=%0d exp 1/1000/3", m_arvalid, m_araddr, m_arlen);
      end
      step();
      checks++;
      if (m_arvalid !== 1'b0) begin failures++; $display("[TB] FAIL single_ar_done got=%b exp=0", m_arvalid); end
      for (int b = 0; b < 4; b++) begin
         m_rvalid = 1'b1;
         m_rdata  = 32'hA0 + b;
         m_rlast  = (b == 3);
         #1;
         checks++;
         if (s_rvalid !== 2'b01 || m_rready !== 1'b1 || s_rdata !== 32'hA0 + b) begin
            failures++; $display("[TB] FAIL single_beat%0d got sv=%b mr=%b d=%h", b, s_rvalid, m_rready, s_rdata);
         end
         step();
      end
      m_rlast = 1'b0;
      #1;
      checks++;
      if (m_rready !== 1'b0 || s_rvalid !== 2'b00) begin
         failures++; $display("[TB] FAIL single_empty got mr=%b sv=%b exp 0/00", m_rready, s_rvalid);
      end
      m_rvalid = 1'b0;
   endtask

   task automatic test_round_robin();
      do_reset();
      set_ar(0, 64'h2000, 8'd1);
      set_ar(1, 64'h3000, 8'd1);
      s_arvalid = 2'b11;
      #1;
      checks++;
      if (s_arready !== 2'b01) begin failures++; $display("[TB] FAIL rr_first got=%b exp=01", s_arready); end
      step();
      s_arvalid = 2'b10;
      #1;
      checks++;
      if (m_araddr !== 64'h2000 || s_arready !== 2'b00) begin
         failures++; $display("[TB] FAIL rr_issue0 got a=%h rdy=%b exp 2000/00", m_araddr, s_arready);
      end
      step();
      checks++;
      if (m_arvalid !== 1'b0 || s_arready !== 2'b10) begin
         failures++; $display("[TB] FAIL rr_second got v=%b rdy=%b exp 0/10", m_arvalid, s_arready);
      end
      step();
      s_arvalid = 2'b00;
      #1;
      checks++;
      if (m_arvalid !== 1'b1 || m_araddr !== 64'h3000) begin
         failures++; $display("[TB] FAIL rr_issue1 got v=%b a=%h exp 1/3000", m_arvalid, m_araddr);
      end
      step();
      for (int b = 0; b < 4; b++) begin
         m_rvalid = 1'b1;
         m_rdata  = 32'hB0 + b;
         m_rlast  = (b % 2 == 1);
         #1;
         checks++;
         if (s_rvalid !== ((b < 2) ? 2'b01 : 2'b10) || s_rdata !== 32'hB0 + b) begin
            failures++; $display("[TB] FAIL rr_beat%0d got sv=%b d=%h", b, s_rvalid, s_rdata);
         end
         step();
      end
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
   endtask

   task automatic test_fifo_full();
      logic [1:0] exp_rv [4];
      exp_rv = '{2'b01, 2'b01, 2'b01, 2'b10};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_ar(0, 64'h100 * (i + 1), 8'd0);
         s_arvalid = 2'b01;
         #1;
         checks++;
         if (s_arready !== 2'b01) begin failures++; $display("[TB] FAIL full_fill%0d got=%b exp=01", i, s_arready); end
         step();
         s_arvalid = 2'b00;
         step();
      end
      set_ar(1, 64'h9000, 8'd0);
      s_arvalid = 2'b10;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (s_arready !== 2'b00) begin failures++; $display("[TB] FAIL full_block%0d got=%b exp=00", c, s_arready); end
         step();
      end
      m_rvalid = 1'b1;
      m_rlast  = 1'b1;
      m_rdata  = 32'hC0;
      #1;
      checks++;
      if (s_rvalid !== 2'b01 || m_rready !== 1'b1) begin
         failures++; $display("[TB] FAIL full_pop got sv=%b mr=%b exp 01/1", s_rvalid, m_rready);
      end
      step();
      m_rvalid = 1'b0;
      #1;
      checks++;
      if (s_arready !== 2'b10) begin failures++; $display("[TB] FAIL full_accept got=%b exp=10", s_arready); end
      step();
      s_arvalid = 2'b00;
      #1;
      checks++;
      if (m_arvalid !== 1'b1 || m_araddr !== 64'h9000) begin
         failures++; $display("[TB] FAIL full_issue got v=%b a=%h exp 1/9000", m_arvalid, m_araddr);
      end
      step();
      for (int b = 0; b < 4; b++) begin
         m_rvalid = 1'b1;
         m_rdata  = 32'hC1 + b;
         #1;
         checks++;
         if (s_rvalid !== exp_rv[b]) begin
            failures++; $display("[TB] FAIL full_drain%0d got=%b exp=%b", b, s_rvalid, exp_rv[b]);
         end
         step();
      end
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
   endtask

   task automatic test_arready_stall_and_reset();
      do_reset();
      m_arready = 1'b0;
      set_ar(1, 64'h4000, 8'd7);
      s_arvalid = 2'b10;
      #1;
      checks++;
      if (s_arready !== 2'b10) begin failures++; $display("[TB] FAIL stall_accept got=%b exp=10", s_arready); end
      step();
      set_ar(1, 64'h4444, 8'd1);
      set_ar(0, 64'h5000, 8'd0);
      s_arvalid = 2'b11;
      for (int c = 0; c < 10; c++) begin
         #1;
         checks++;
         if (m_arvalid !== 1'b1 || m_araddr !== 64'h4000 || m_arlen !== 8'd7 || s_arready !== 2'b00) begin
            failures++;
            $display("[TB] FAIL stall_hold%0d got v=%b a=%h l=%0d rdy=%b", c, m_arvalid, m_araddr, m_arlen, s_arready);
         end
         step();
      end
      m_arready = 1'b1;
      step();
      checks++;
      if (m_arvalid !== 1'b0 || s_arready !== 2'b01) begin
         failures++; $display("[TB] FAIL stall_release got v=%b rdy=%b exp 0/01", m_arvalid, s_arready);
      end
      step();
      s_arvalid = 2'b00;
      #1;
      checks++;
      if (m_araddr !== 64'h5000) begin failures++; $display("[TB] FAIL stall_next got=%h exp=5000", m_araddr); end
      step();
      m_rvalid = 1'b1;
      m_rlast  = 1'b0;
      #1;
      checks++;
      if (s_rvalid !== 2'b10) begin failures++; $display("[TB] FAIL midrst_head got=%b exp=10", s_rvalid); end
      step();
      reset = 1'b1;
      step();
      checks++;
      if (m_arvalid !== 1'b0 || m_araddr !== '0 || m_arlen !== '0 || m_arsize !== '0 ||
          s_arready !== 2'b00 || s_rvalid !== 2'b00 || m_rready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrst_outputs got v=%b a=%h l=%h sz=%h rdy=%b sv=%b mr=%b",
                  m_arvalid, m_araddr, m_arlen, m_arsize, s_arready, s_rvalid, m_rready);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (m_rready !== 1'b0 || s_rvalid !== 2'b00) begin
         failures++; $display("[TB] FAIL midrst_count got mr=%b sv=%b exp 0/00", m_rready, s_rvalid);
      end
      m_rvalid = 1'b0;
      s_arvalid = 2'b01;
      #1;
      checks++;
      if (s_arready !== 2'b01) begin failures++; $display("[TB] FAIL midrst_idle got=%b exp=01", s_arready); end
      s_arvalid = 2'b00;
   endtask

   task automatic test_rready_backpressure();
      logic [DW-1:0] seen [$];
      do_reset();
      set_ar(0, 64'h6000, 8'd2);
      s_arvalid = 2'b01;
      step();
      s_arvalid = 2'b00;
      step();
      for (int b = 0; b < 3; b++) begin
         m_rvalid = 1'b1;
         m_rdata  = 32'h10 + b;
         m_rlast  = (b == 2);
         if (b == 1) begin
            s_rready = 2'b00;
            for (int c = 0; c < 3; c++) begin
               #1;
               checks++;
               if (m_rready !== 1'b0 || s_rvalid !== 2'b01 || s_rdata !== 32'h11) begin
                  failures++; $display("[TB] FAIL bp_hold%0d got mr=%b sv=%b d=%h", c, m_rready, s_rvalid, s_rdata);
               end
               if (m_rvalid && m_rready) seen.push_back(s_rdata);
               step();
            end
            s_rready = 2'b01;
         end
         #1;
         if (m_rvalid && m_rready) seen.push_back(s_rdata);
         step();
      end
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      s_rready = 2'b11;
      checks++;
      if (seen.size() != 3) begin
         failures++; $display("[TB] FAIL bp_count got=%0d exp=3", seen.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (seen[i] !== 32'h10 + i) begin failures++; $display("[TB] FAIL bp_data%0d got=%h exp=%h", i, seen[i], 32'h10 + i); end
         end
      end
      m_rvalid = 1'b1;
      #1;
      checks++;
      if (m_rready !== 1'b0) begin failures++; $display("[TB] FAIL bp_empty got=%b exp=0", m_rready); end
      m_rvalid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_round_robin();
      test_fifo_full();
      test_arready_stall_and_reset();
      test_rready_backpressure();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
